out_buf: RTL and testbench

Parametrised, buffered successor to the SAP output register. The CPU writes bus values with `out_write`. Values queue in a DEPTH-entry FIFO instead of overwriting a single register. A downstream consumer (display driver, UART bridge) drains the FIFO with a valid/ready handshake. A `display` register holds the most recently drained value for static indicators. Sits on the CPU bus beside the accumulator and RAM, and feeds `out_full` back to the control unit as a stall hint.

---
 rtl/sap_pkg.sv | 8 +
 rtl/out_buf_mem.sv | 30 +++
 rtl/out_buf.sv | 98 +++++++++
 tb/tb_out_buf.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared SAP definitions: bus width and the data word type.
package sap_pkg;

   localparam int DATA_W = 16;

   typedef logic [DATA_W-1:0] data_t;

endpackage : sap_pkg

// File: rtl/out_buf_mem.sv
// Storage array for out_buf: DEPTH x WIDTH registers, one synchronous
// write port and one asynchronous read port. No reset, since contents are
// only ever read behind a valid occupancy count.
module out_buf_mem
   import sap_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write the addressed entry on an accepted push.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule : out_buf_mem

// File: rtl/out_buf.sv
// out_buf: buffered CPU output port. Bus writes queue in a DEPTH-entry
// FIFO, a consumer drains it with valid/ready, and `display` holds the
// most recently drained value.
// Optional feature: define OUT_BUF_OVF_FLAG_EN to build a sticky
// overflow flag set by any dropped push; otherwise `ovf` is tied low.
module out_buf
   import sap_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] bus,
   input  logic             out_write,
   output logic             out_full,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] display,
   output logic [CW-1:0]    count,
   output logic             ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop;

   // Flags decode from the registered count only, so the control unit
   // sees no combinational path from out_write/out_ready.
   assign out_full  = (count == FULL_CNT);
   assign out_valid = (count != '0);

   // A push against a full FIFO is dropped even if a pop frees a slot on
   // the same edge; fullness is judged on current state.
   assign push = out_write & ~out_full;
   assign pop  = out_valid & out_ready;

   out_buf_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (bus),
      .raddr (rd_ptr),
      .rdata (out_data)
   );

   // Pointers wrap naturally at DEPTH (power of two); count tracks
   // occupancy explicitly so full and empty are unambiguous.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

   // Capture the head entry as it leaves, for static indicators.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         display <= '0;
      end else if (pop) begin
         display <= out_data;
      end
   end

`ifdef OUT_BUF_OVF_FLAG_EN
   logic ovf_q;

   // Sticky until reset: any push presented while full.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (out_write && out_full) begin
         ovf_q <= 1'b1;
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

endmodule : out_buf

// File: tb/tb_out_buf.sv
// Self-checking bench for out_buf (DEPTH=4, WIDTH=16). A queue-based
// reference model tracks contents, display and the overflow flag.
module tb_out_buf;

   localparam int WIDTH = 16;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] bus;
   logic             out_write;
   logic             out_full;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] display;
   logic [CW-1:0]    count;
   logic             ovf;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [WIDTH-1:0] m_q[$];
   logic [WIDTH-1:0] m_disp;
   logic             m_ovf;

`ifdef OUT_BUF_OVF_FLAG_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   out_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .out_write (out_write),
      .out_full  (out_full),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .display   (display),
      .count     (count),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs, advance the model across the rising edge,
   // and return at the following falling edge for sampling.
   task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r);
      int sz;
      out_write = w;
      bus       = d;
      out_ready = r;
      @(posedge clk);
      if (!rst_n) begin
         m_q.delete();
         m_disp = '0;
         m_ovf  = 1'b0;
      end else begin
         sz = m_q.size();
         if (w && sz == DEPTH && OVF_EN) m_ovf = 1'b1;
         if (r && sz != 0) m_disp = m_q.pop_front();
         if (w && sz != DEPTH) m_q.push_back(d);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step(1'b1, 16'h1234, 1'b0);
      step(1'b1, 16'h5678, 1'b1);
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
      checks++; if (display !== 16'h0) begin errors++; $display("FAIL reset_display got %h exp 0000", display); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
      rst_n = 1'b1;
   endtask

   task automatic test_fill_drain();
      logic [WIDTH-1:0] exp;
      for (int i = 1; i <= 4; i++) step(1'b1, WIDTH'(16'h0011 * i), 1'b0);
      checks++; if (out_full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", out_full); end
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", count); end
      checks++; if (out_data !== 16'h0011) begin errors++; $display("FAIL fill_head got %h exp 0011", out_data); end
      for (int i = 1; i <= 4; i++) begin
         step(1'b0, '0, 1'b1);
         exp = WIDTH'(16'h0011 * i);
         checks++; if (display !== exp) begin errors++; $display("FAIL drain_display[%0d] got %h exp %h", i, display, exp); end
      end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b exp 0", out_valid); end
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 4; i++) step(1'b1, WIDTH'(16'h0011 * i), 1'b0);
      step(1'b1, 16'h0055, 1'b1);
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL ovf_count got %0d exp 3", count); end
      checks++; if (display !== 16'h0011) begin errors++; $display("FAIL ovf_display got %h exp 0011", display); end
      checks++; if (out_data !== 16'h0022) begin errors++; $display("FAIL ovf_head got %h exp 0022", out_data); end
      checks++; if (ovf !== OVF_EN) begin errors++; $display("FAIL ovf_flag got %b exp %b", ovf, OVF_EN); end
      // drain the rest; 0x0055 must never appear
      for (int i = 2; i <= 4; i++) begin
         step(1'b0, '0, 1'b1);
         checks++; if (display !== WIDTH'(16'h0011 * i)) begin errors++; $display("FAIL ovf_drain[%0d] got %h exp %h", i, display, WIDTH'(16'h0011 * i)); end
      end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL ovf_empty got %0d exp 0", count); end
   endtask

   task automatic test_empty_pop();
      step(1'b0, 16'hFFFF, 1'b1);
      step(1'b0, 16'hFFFF, 1'b1);
      checks++; if (display !== 16'h0044) begin errors++; $display("FAIL empty_display got %h exp 0044", display); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL empty_count got %0d exp 0", count); end
   endtask

   task automatic test_stream();
      for (int i = 0; i < 20; i++) begin
         step(1'b1, WIDTH'(16'h0100 + i), 1'b1);
         checks++; if (count !== 3'd1) begin errors++; $display("FAIL stream_count[%0d] got %0d exp 1", i, count); end
         checks++; if (out_data !== WIDTH'(16'h0100 + i)) begin errors++; $display("FAIL stream_head[%0d] got %h exp %h", i, out_data, WIDTH'(16'h0100 + i)); end
         if (i > 0) begin
            checks++; if (display !== WIDTH'(16'h0100 + i - 1)) begin errors++; $display("FAIL stream_display[%0d] got %h exp %h", i, display, WIDTH'(16'h0100 + i - 1)); end
         end
      end
      step(1'b0, '0, 1'b1);
      checks++; if (display !== 16'h0113) begin errors++; $display("FAIL stream_last got %h exp 0113", display); end
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 3; i++) step(1'b1, WIDTH'(16'h0700 + i), 1'b0);
      rst_n = 1'b0;
      step(1'b1, 16'h0DEF, 1'b1);
      rst_n = 1'b1;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL midrst_count got %0d exp 0", count); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", out_valid); end
      checks++; if (display !== 16'h0) begin errors++; $display("FAIL midrst_display got %h exp 0000", display); end
      step(1'b1, 16'h0ABC, 1'b0);
      checks++; if (out_valid !== 1'b1 || out_data !== 16'h0ABC) begin errors++; $display("FAIL midrst_push got v=%b d=%h exp v=1 d=0abc", out_valid, out_data); end
   endtask

   task automatic test_random();
      logic             w, r;
      logic [WIDTH-1:0] d;
      logic [CW-1:0]    exp_cnt;
      for (int i = 0; i < 400; i++) begin
         w = ($urandom_range(0, 99) < 60);
         r = ($urandom_range(0, 99) < 45);
         d = WIDTH'($urandom);
         rst_n = ($urandom_range(0, 99) != 0);
         step(w, d, r);
         rst_n = 1'b1;
         exp_cnt = CW'(m_q.size());
         checks++; if (count !== exp_cnt) begin errors++; $display("FAIL rnd_count[%0d] got %0d exp %0d", i, count, exp_cnt); end
         checks++; if (out_full !== (m_q.size() == DEPTH)) begin errors++; $display("FAIL rnd_full[%0d] got %b exp %b", i, out_full, m_q.size() == DEPTH); end
         checks++; if (out_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_valid[%0d] got %b exp %b", i, out_valid, m_q.size() != 0); end
         if (m_q.size() != 0) begin
            checks++; if (out_data !== m_q[0]) begin errors++; $display("FAIL rnd_head[%0d] got %h exp %h", i, out_data, m_q[0]); end
         end
         checks++; if (display !== m_disp) begin errors++; $display("FAIL rnd_display[%0d] got %h exp %h", i, display, m_disp); end
         checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL rnd_ovf[%0d] got %b exp %b", i, ovf, m_ovf); end
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      bus       = '0;
      out_write = 1'b0;
      out_ready = 1'b0;
      m_disp    = '0;
      m_ovf     = 1'b0;
      test_reset();
      test_fill_drain();
      test_overflow();
      test_empty_pop();
      test_stream();
      test_mid_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_out_buf
